// File: rtl/sol1_bus_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pa_cpu : shared definitions for the SOL-1 external bus path.
//   e_bus_state  - bus controller sequencing states
//   e_bus_target - decoded access target (ROM / RAM / I/O)
//   IO_SEL_HI/LO - address bits that pick one of the four I/O selects
//   io_cs_decode - turns the I/O select field into active-low chip selects
// Imported by the bus controller, its decoder and (later) the DMA path.
// ---------------------------------------------------------------------------
package pa_cpu;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } e_bus_state;

  typedef enum logic [1:0] {
    TGT_ROM,
    TGT_RAM,
    TGT_IO
  } e_bus_target;

  localparam int IO_SEL_HI = 7;
  localparam int IO_SEL_LO = 6;

  // Select field 0 drives io_cs_n[3], field 3 drives io_cs_n[0]; the board
  // wiring numbers the selects from the top down.
  function automatic logic [3:0] io_cs_decode(input logic [1:0] sel);
    return ~(4'b1000 >> sel);
  endfunction

endpackage

// File: rtl/sol1_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// sol1_bus_ctrl_if : CPU-side bus between the SOL-1 core and its bus
// controller.
//   address_bus  [21:0]  address from CPU
//   data_bus_out [7:0]   write data from CPU
//   rd, wr               active-low strobes from CPU
//   mem_io               1 = memory cycle, 0 = I/O cycle
//   data_bus_in  [7:0]   read data back to CPU
//   pin_wait             stall request back to CPU
// Modports: master = CPU core, slave = bus controller.
// ---------------------------------------------------------------------------
interface sol1_bus_ctrl_if;

  logic [21:0] address_bus;
  logic [7:0]  data_bus_out;
  logic        rd;
  logic        wr;
  logic        mem_io;
  logic [7:0]  data_bus_in;
  logic        pin_wait;

  modport master (
    output address_bus, data_bus_out, rd, wr, mem_io,
    input  data_bus_in, pin_wait
  );

  modport slave (
    input  address_bus, data_bus_out, rd, wr, mem_io,
    output data_bus_in, pin_wait
  );

endinterface

// File: rtl/sol1_bus_decode.sv
// ---------------------------------------------------------------------------
// sol1_bus_decode : combinational target and I/O chip-select decode.
//   addr_i     [21:0]  address to decode
//   mem_io_i           1 = memory space, 0 = I/O space
//   target_o           ROM at or below ROM_TOP, RAM above it, I/O otherwise
//   io_cs_n_o  [3:0]   active-low I/O select pattern (all high for memory)
// Shared with the DMA path, so it carries no state of its own.
// ---------------------------------------------------------------------------
module sol1_bus_decode
  import pa_cpu::*;
#(
  parameter logic [21:0] ROM_TOP = 22'h00_7FFF
) (
  input  logic [21:0] addr_i,
  input  logic        mem_io_i,
  output e_bus_target target_o,
  output logic [3:0]  io_cs_n_o
);

  // Memory space splits at ROM_TOP; everything in I/O space goes to one of
  // the four peripheral selects picked by the select field of the address.
  always_comb begin
    target_o  = TGT_IO;
    io_cs_n_o = 4'hF;
    if (mem_io_i) begin
      target_o = (addr_i <= ROM_TOP) ? TGT_ROM : TGT_RAM;
    end else begin
      io_cs_n_o = io_cs_decode(addr_i[IO_SEL_HI:IO_SEL_LO]);
    end
  end

endmodule

// File: rtl/sol1_bus_ctrl.sv
// ---------------------------------------------------------------------------
// sol1_bus_ctrl : external bus controller for the SOL-1 CPU.
//   clk, arst            clock, synchronous active-high reset
//   cpu                  CPU-side bus (slave modport of sol1_bus_ctrl_if)
//   ext_addr, ext_data_out  registered address / write data to the boards
//   ext_data_in          read data from the boards
//   rom_cs_n, ram_cs_n, io_cs_n[3:0]  active-low chip selects
//   ext_rd_n, ext_wr_n   active-low board strobes
//   io_ready             slow peripheral ready
//   bus_error            one-cycle pulse on I/O timeout or rd/wr clash
// Each access runs IDLE -> SETUP -> ACCESS -> DONE; the CPU is stalled from
// the cycle it raises a strobe until DONE.
// ---------------------------------------------------------------------------
module sol1_bus_ctrl
  import pa_cpu::*;
#(
  parameter logic [21:0] ROM_TOP    = 22'h00_7FFF,
  parameter int          ROM_WAIT   = 2,
  parameter int          RAM_WAIT   = 0,
  parameter int          IO_WAIT    = 1,
  parameter int          IO_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 arst,
  sol1_bus_ctrl_if.slave       cpu,
  output logic [21:0]          ext_addr,
  output logic [7:0]           ext_data_out,
  input  logic [7:0]           ext_data_in,
  output logic                 rom_cs_n,
  output logic                 ram_cs_n,
  output logic [3:0]           io_cs_n,
  output logic                 ext_rd_n,
  output logic                 ext_wr_n,
  input  logic                 io_ready,
  output logic                 bus_error
);

  localparam int MAX_MEM = (ROM_WAIT > RAM_WAIT) ? ROM_WAIT : RAM_WAIT;
  localparam int MAX_WT  = (MAX_MEM > IO_WAIT) ? MAX_MEM : IO_WAIT;
  localparam int MAX_ALL = (MAX_WT > IO_TIMEOUT) ? MAX_WT : IO_TIMEOUT;
  localparam int CW      = $clog2(MAX_ALL + 1);

  // The timeout counter starts at 0 on the first ACCESS cycle, so the abort
  // fires on the IO_TIMEOUT-th cycle spent there.
  localparam logic [CW-1:0] TMO_LAST = CW'(IO_TIMEOUT - 1);

  e_bus_state  state_q, state_d;
  e_bus_target target_q, target_d;
  logic [3:0]  io_cs_q, io_cs_d;
  logic [21:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        mem_io_q, mem_io_d;
  logic        op_wr_q, op_wr_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  logic        clash_q, clash_d;

  logic        req;
  logic        clash;
  logic        active;
  e_bus_target dec_target;
  logic [3:0]  dec_io_cs_n;

  assign req   = cpu.rd ^ cpu.wr;
  assign clash = ~cpu.rd & ~cpu.wr;

  sol1_bus_decode #(
    .ROM_TOP(ROM_TOP)
  ) u_decode (
    .addr_i   (cpu.address_bus),
    .mem_io_i (cpu.mem_io),
    .target_o (dec_target),
    .io_cs_n_o(dec_io_cs_n)
  );

  // State and datapath registers; reset drops every select and strobe at
  // the same edge and suppresses any pending error pulse.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q  <= IDLE;
      target_q <= TGT_ROM;
      io_cs_q  <= 4'hF;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= 8'h00;
      mem_io_q <= 1'b0;
      op_wr_q  <= 1'b0;
      wait_q   <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      clash_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      io_cs_q  <= io_cs_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      mem_io_q <= mem_io_d;
      op_wr_q  <= op_wr_d;
      wait_q   <= wait_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      clash_q  <= clash_d;
    end
  end

  // Next-state logic. A rd/wr clash is flagged only on its first cycle so
  // a CPU that holds both strobes low still sees a single error pulse.
  // Memory targets finish when the wait counter reaches zero; I/O also needs
  // io_ready, and a ready seen on the abort cycle still wins.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    io_cs_d  = io_cs_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    mem_io_d = mem_io_q;
    op_wr_d  = op_wr_q;
    wait_d   = wait_q;
    tmo_d    = tmo_q;
    err_d    = 1'b0;
    clash_d  = clash;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d   = cpu.address_bus;
          wdata_d  = cpu.data_bus_out;
          mem_io_d = cpu.mem_io;
          op_wr_d  = ~cpu.wr;
          target_d = dec_target;
          io_cs_d  = dec_io_cs_n;
          tmo_d    = '0;
          case (dec_target)
            TGT_ROM: wait_d = CW'(ROM_WAIT);
            TGT_RAM: wait_d = CW'(RAM_WAIT);
            default: wait_d = CW'(IO_WAIT);
          endcase
          state_d = SETUP;
        end else if (clash && !clash_q) begin
          err_d = 1'b1;
        end
      end

      SETUP: begin
        tmo_d   = '0;
        state_d = ACCESS;
      end

      ACCESS: begin
        if (wait_q != '0) begin
          wait_d = wait_q - 1'b1;
        end
        if (target_q != TGT_IO) begin
          if (wait_q == '0) begin
            if (!op_wr_q) begin
              rdata_d = ext_data_in;
            end
            state_d = DONE;
          end
        end else if (wait_q == '0 && io_ready) begin
          if (!op_wr_q) begin
            rdata_d = ext_data_in;
          end
          state_d = DONE;
        end else if (tmo_q == TMO_LAST) begin
          rdata_d = 8'hFF;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      DONE: begin
        if (!req || cpu.address_bus != addr_q || cpu.mem_io != mem_io_q ||
            (~cpu.wr) != op_wr_q) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Selects cover SETUP and ACCESS; strobes only ACCESS, giving one cycle of
  // address setup before the board sees a read or write.
  assign active = (state_q == SETUP) || (state_q == ACCESS);

  assign rom_cs_n     = ~(active && target_q == TGT_ROM);
  assign ram_cs_n     = ~(active && target_q == TGT_RAM);
  assign io_cs_n      = (active && target_q == TGT_IO) ? io_cs_q : 4'hF;
  assign ext_rd_n     = ~(state_q == ACCESS && !op_wr_q);
  assign ext_wr_n     = ~(state_q == ACCESS && op_wr_q);
  assign ext_addr     = addr_q;
  assign ext_data_out = wdata_q;
  assign bus_error    = err_q;

  assign cpu.data_bus_in = rdata_q;
  assign cpu.pin_wait    = req && (state_q != DONE);

endmodule

// File: tb/tb_sol1_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sol1_bus_ctrl : directed bench for sol1_bus_ctrl with default
// parameters. Each vector is one clock cycle: inputs are driven, outputs
// are compared shortly afterwards, then the clock advances.
// ---------------------------------------------------------------------------
module tb_sol1_bus_ctrl;

  logic        clk = 1'b0;
  logic        arst;
  logic [21:0] ext_addr;
  logic [7:0]  ext_data_out;
  logic [7:0]  ext_data_in;
  logic        rom_cs_n;
  logic        ram_cs_n;
  logic [3:0]  io_cs_n;
  logic        ext_rd_n;
  logic        ext_wr_n;
  logic        io_ready;
  logic        bus_error;

  int nVec = 0;
  int nErr = 0;

  sol1_bus_ctrl_if cpuBus();

  sol1_bus_ctrl dut (
    .clk         (clk),
    .arst        (arst),
    .cpu         (cpuBus),
    .ext_addr    (ext_addr),
    .ext_data_out(ext_data_out),
    .ext_data_in (ext_data_in),
    .rom_cs_n    (rom_cs_n),
    .ram_cs_n    (ram_cs_n),
    .io_cs_n     (io_cs_n),
    .ext_rd_n    (ext_rd_n),
    .ext_wr_n    (ext_wr_n),
    .io_ready    (io_ready),
    .bus_error   (bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        memIo;
    logic [21:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    logic        ioRdy;
    logic [17:0] expOut;
    logic [21:0] expAddr;
    logic [7:0]  expWdata;
  } vec_t;

  vec_t tbl[$];

  localparam logic [21:0] A_ROM  = 22'h000010;
  localparam logic [21:0] A_RAM  = 22'h010000;
  localparam logic [21:0] A_RAM0 = 22'h008000;
  localparam logic [21:0] A_ROMT = 22'h007FFF;
  localparam logic [21:0] A_IO2  = 22'h000080;
  localparam logic [21:0] A_IO3  = 22'h0000C0;
  localparam logic [21:0] A_ROM2 = 22'h000020;

  // Packed expected outputs: pin_wait, rom_cs_n, ram_cs_n, io_cs_n,
  // ext_rd_n, ext_wr_n, bus_error, data_bus_in.
  function automatic logic [17:0] po(input logic pw, input logic rom,
                                     input logic ram, input logic [3:0] io,
                                     input logic rdn, input logic wrn,
                                     input logic err, input logic [7:0] data);
    return {pw, rom, ram, io, rdn, wrn, err, data};
  endfunction

  function automatic vec_t mk(input logic rd, input logic wr,
                              input logic memIo, input logic [21:0] addr,
                              input logic [7:0] wdata, input logic [7:0] din,
                              input logic ioRdy, input logic [17:0] expOut,
                              input logic [21:0] expAddr,
                              input logic [7:0] expWdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.memIo = memIo; v.addr = addr;
    v.wdata = wdata; v.din = din; v.ioRdy = ioRdy;
    v.expOut = expOut; v.expAddr = expAddr; v.expWdata = expWdata;
    return v;
  endfunction

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic memIo, input logic [21:0] addr,
                               input logic [7:0] wdata, input logic [7:0] din,
                               input logic ioRdy, input logic rst);
    cpuBus.rd           = rd;
    cpuBus.wr           = wr;
    cpuBus.mem_io       = memIo;
    cpuBus.address_bus  = addr;
    cpuBus.data_bus_out = wdata;
    ext_data_in         = din;
    io_ready            = ioRdy;
    arst                = rst;
  endtask

  task automatic checkOutput(input string tag, input logic [17:0] expOut,
                             input logic [21:0] expAddr,
                             input logic [7:0] expWdata);
    logic [17:0] act;
    act = {cpuBus.pin_wait, rom_cs_n, ram_cs_n, io_cs_n, ext_rd_n, ext_wr_n,
           bus_error, cpuBus.data_bus_in};
    nVec++;
    if (act !== expOut || ext_addr !== expAddr || ext_data_out !== expWdata) begin
      nErr++;
      $display("[TB] FAIL %s: outs=%h want %h, ext_addr=%h want %h, ext_data_out=%h want %h",
               tag, act, expOut, ext_addr, expAddr, ext_data_out, expWdata);
    end
  endtask

  // One cycle: drive, let combinational outputs settle, compare, advance.
  task automatic step(input string tag, input logic rd, input logic wr,
                      input logic memIo, input logic [21:0] addr,
                      input logic [7:0] wdata, input logic [7:0] din,
                      input logic ioRdy, input logic rst,
                      input logic [17:0] expOut, input logic [21:0] expAddr,
                      input logic [7:0] expWdata);
    applyStimulus(rd, wr, memIo, addr, wdata, din, ioRdy, rst);
    #1;
    checkOutput(tag, expOut, expAddr, expWdata);
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset state, then ROM read with two wait states (data latched on the
    // last ACCESS cycle only, so neighbouring ext_data_in values differ).
    tbl.push_back(mk(1,1,1,A_ROM ,8'h00,8'h00,0, po(0,1,1,4'hF,1,1,0,8'h00), 22'h0 ,8'h00));
    tbl.push_back(mk(0,1,1,A_ROM ,8'h00,8'h00,0, po(1,1,1,4'hF,1,1,0,8'h00), 22'h0 ,8'h00));
    tbl.push_back(mk(0,1,1,A_ROM ,8'h00,8'h00,0, po(1,0,1,4'hF,1,1,0,8'h00), A_ROM ,8'h00));
    tbl.push_back(mk(0,1,1,A_ROM ,8'h00,8'h5A,0, po(1,0,1,4'hF,0,1,0,8'h00), A_ROM ,8'h00));
    tbl.push_back(mk(0,1,1,A_ROM ,8'h00,8'h5A,0, po(1,0,1,4'hF,0,1,0,8'h00), A_ROM ,8'h00));
    tbl.push_back(mk(0,1,1,A_ROM ,8'h00,8'hA5,0, po(1,0,1,4'hF,0,1,0,8'h00), A_ROM ,8'h00));
    tbl.push_back(mk(0,1,1,A_ROM ,8'h00,8'h11,0, po(0,1,1,4'hF,1,1,0,8'hA5), A_ROM ,8'h00));
    tbl.push_back(mk(1,1,1,A_ROM ,8'h00,8'h11,0, po(0,1,1,4'hF,1,1,0,8'hA5), A_ROM ,8'h00));
    tbl.push_back(mk(1,1,1,A_ROM ,8'h00,8'h11,0, po(0,1,1,4'hF,1,1,0,8'hA5), A_ROM ,8'h00));
    // RAM write, zero wait states; CPU data changes after capture.
    tbl.push_back(mk(1,0,1,A_RAM ,8'h3C,8'h00,0, po(1,1,1,4'hF,1,1,0,8'hA5), A_ROM ,8'h00));
    tbl.push_back(mk(1,0,1,A_RAM ,8'hC3,8'h00,0, po(1,1,0,4'hF,1,1,0,8'hA5), A_RAM ,8'h3C));
    tbl.push_back(mk(1,0,1,A_RAM ,8'hC3,8'h00,0, po(1,1,0,4'hF,1,0,0,8'hA5), A_RAM ,8'h3C));
    tbl.push_back(mk(1,0,1,A_RAM ,8'hC3,8'h00,0, po(0,1,1,4'hF,1,1,0,8'hA5), A_RAM ,8'h3C));
    tbl.push_back(mk(1,1,1,A_RAM ,8'hC3,8'h00,0, po(0,1,1,4'hF,1,1,0,8'hA5), A_RAM ,8'h3C));
    // rd and wr low together for two cycles: a single error pulse, no access.
    tbl.push_back(mk(0,0,1,A_RAM ,8'h00,8'h00,0, po(0,1,1,4'hF,1,1,0,8'hA5), A_RAM ,8'h3C));
    tbl.push_back(mk(0,0,1,A_RAM ,8'h00,8'h00,0, po(0,1,1,4'hF,1,1,1,8'hA5), A_RAM ,8'h3C));
    tbl.push_back(mk(1,1,1,A_RAM ,8'h00,8'h00,0, po(0,1,1,4'hF,1,1,0,8'hA5), A_RAM ,8'h3C));
    // First RAM address above ROM_TOP; DONE left by an address change
    // straight into a ROM read of the last ROM address.
    tbl.push_back(mk(0,1,1,A_RAM0,8'h00,8'h00,0, po(1,1,1,4'hF,1,1,0,8'hA5), A_RAM ,8'h3C));
    tbl.push_back(mk(0,1,1,A_RAM0,8'h00,8'h00,0, po(1,1,0,4'hF,1,1,0,8'hA5), A_RAM0,8'h00));
    tbl.push_back(mk(0,1,1,A_RAM0,8'h00,8'h9C,0, po(1,1,0,4'hF,0,1,0,8'hA5), A_RAM0,8'h00));
    tbl.push_back(mk(0,1,1,A_ROMT,8'h00,8'h00,0, po(0,1,1,4'hF,1,1,0,8'h9C), A_RAM0,8'h00));
    tbl.push_back(mk(0,1,1,A_ROMT,8'h00,8'h00,0, po(1,1,1,4'hF,1,1,0,8'h9C), A_RAM0,8'h00));
    tbl.push_back(mk(0,1,1,A_ROMT,8'h00,8'h00,0, po(1,0,1,4'hF,1,1,0,8'h9C), A_ROMT,8'h00));
    tbl.push_back(mk(0,1,1,A_ROMT,8'h00,8'h00,0, po(1,0,1,4'hF,0,1,0,8'h9C), A_ROMT,8'h00));
    tbl.push_back(mk(0,1,1,A_ROMT,8'h00,8'h00,0, po(1,0,1,4'hF,0,1,0,8'h9C), A_ROMT,8'h00));
    tbl.push_back(mk(0,1,1,A_ROMT,8'h00,8'hE1,0, po(1,0,1,4'hF,0,1,0,8'h9C), A_ROMT,8'h00));
    tbl.push_back(mk(0,1,1,A_ROMT,8'h00,8'h00,0, po(0,1,1,4'hF,1,1,0,8'hE1), A_ROMT,8'h00));
    tbl.push_back(mk(1,1,1,A_ROMT,8'h00,8'h00,0, po(0,1,1,4'hF,1,1,0,8'hE1), A_ROMT,8'h00));
    tbl.push_back(mk(1,1,1,A_ROMT,8'h00,8'h00,0, po(0,1,1,4'hF,1,1,0,8'hE1), A_ROMT,8'h00));

    applyStimulus(1, 1, 1, 22'h0, 8'h00, 8'h00, 0, 1);
    repeat (2) @(posedge clk);
    #2;
    arst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].memIo,
           tbl[i].addr, tbl[i].wdata, tbl[i].din, tbl[i].ioRdy, 1'b0,
           tbl[i].expOut, tbl[i].expAddr, tbl[i].expWdata);
    end

    // I/O read of select 2 (io_cs_n = 1101); io_ready rises on the seventh
    // ACCESS cycle and its data is latched there.
    step("io_idle" , 0,1,0,A_IO2,8'h00,8'h00,0,0, po(1,1,1,4'hF,1,1,0,8'hE1), A_ROMT,8'h00);
    step("io_setup", 0,1,0,A_IO2,8'h00,8'h00,0,0, po(1,1,1,4'hD,1,1,0,8'hE1), A_IO2 ,8'h00);
    for (int k = 0; k <= 6; k++) begin
      step($sformatf("io_acc%0d", k), 0,1,0,A_IO2,8'h00,(k == 6) ? 8'hC7 : 8'h00,
           (k == 6), 0, po(1,1,1,4'hD,0,1,0,8'hE1), A_IO2, 8'h00);
    end
    step("io_done" , 0,1,0,A_IO2,8'h00,8'h00,0,0, po(0,1,1,4'hF,1,1,0,8'hC7), A_IO2 ,8'h00);
    step("io_exit" , 1,1,0,A_IO2,8'h00,8'h00,0,0, po(0,1,1,4'hF,1,1,0,8'hC7), A_IO2 ,8'h00);

    // I/O read of select 3 (io_cs_n = 1110) that never becomes ready:
    // aborted after 255 ACCESS cycles with FF data and one error pulse.
    step("to_idle" , 0,1,0,A_IO3,8'h00,8'h5A,0,0, po(1,1,1,4'hF,1,1,0,8'hC7), A_IO2 ,8'h00);
    step("to_setup", 0,1,0,A_IO3,8'h00,8'h5A,0,0, po(1,1,1,4'hE,1,1,0,8'hC7), A_IO3 ,8'h00);
    for (int k = 0; k < 255; k++) begin
      step($sformatf("to_acc%0d", k), 0,1,0,A_IO3,8'h00,8'h5A,0,0,
           po(1,1,1,4'hE,0,1,0,8'hC7), A_IO3, 8'h00);
    end
    step("to_done" , 0,1,0,A_IO3,8'h00,8'h5A,0,0, po(0,1,1,4'hF,1,1,1,8'hFF), A_IO3 ,8'h00);
    step("to_hold" , 0,1,0,A_IO3,8'h00,8'h5A,0,0, po(0,1,1,4'hF,1,1,0,8'hFF), A_IO3 ,8'h00);
    step("to_exit" , 1,1,0,A_IO3,8'h00,8'h5A,0,0, po(0,1,1,4'hF,1,1,0,8'hFF), A_IO3 ,8'h00);

    // Reset during the first ACCESS cycle of a ROM read, then a clean read.
    step("rs_idle" , 0,1,1,A_ROM2,8'h00,8'h00,0,0, po(1,1,1,4'hF,1,1,0,8'hFF), A_IO3 ,8'h00);
    step("rs_setup", 0,1,1,A_ROM2,8'h00,8'h00,0,0, po(1,0,1,4'hF,1,1,0,8'hFF), A_ROM2,8'h00);
    step("rs_acc"  , 0,1,1,A_ROM2,8'h00,8'h00,0,1, po(1,0,1,4'hF,0,1,0,8'hFF), A_ROM2,8'h00);
    step("rs_after", 1,1,1,A_ROM2,8'h00,8'h00,0,0, po(0,1,1,4'hF,1,1,0,8'h00), 22'h0 ,8'h00);
    step("rr_idle" , 0,1,1,A_ROM2,8'h00,8'h00,0,0, po(1,1,1,4'hF,1,1,0,8'h00), 22'h0 ,8'h00);
    step("rr_setup", 0,1,1,A_ROM2,8'h00,8'h00,0,0, po(1,0,1,4'hF,1,1,0,8'h00), A_ROM2,8'h00);
    step("rr_acc0" , 0,1,1,A_ROM2,8'h00,8'h00,0,0, po(1,0,1,4'hF,0,1,0,8'h00), A_ROM2,8'h00);
    step("rr_acc1" , 0,1,1,A_ROM2,8'h00,8'h00,0,0, po(1,0,1,4'hF,0,1,0,8'h00), A_ROM2,8'h00);
    step("rr_acc2" , 0,1,1,A_ROM2,8'h00,8'hB4,0,0, po(1,0,1,4'hF,0,1,0,8'h00), A_ROM2,8'h00);
    step("rr_done" , 0,1,1,A_ROM2,8'h00,8'h00,0,0, po(0,1,1,4'hF,1,1,0,8'hB4), A_ROM2,8'h00);
    step("rr_exit" , 1,1,1,A_ROM2,8'h00,8'h00,0,0, po(0,1,1,4'hF,1,1,0,8'hB4), A_ROM2,8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
